// File: rtl/beat_tempo_tracker.sv
`default_nettype none
// ============================================================================
// beat_tempo_tracker: windowed beat-interval averager with sequential BPM divide
// Revision 1.0
// ============================================================================
module beat_tempo_tracker #(
  parameter int SAMPLE_RATE = 96000,
  parameter int DEPTH       = 8,
  parameter int MIN_BPM     = 40,
  parameter int MAX_BPM     = 200,
  parameter int BPM_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sample_valid,
  input  logic                 beat_in,
  input  logic                 clear,
  output logic [BPM_WIDTH-1:0] bpm_val,
  output logic                 bpm_valid,
  output logic                 locked,
  output logic                 beat_out,
  output logic [1:0]           state
);

  localparam int MAX_INT  = 60 * SAMPLE_RATE / MIN_BPM;
  localparam int MIN_INT  = 60 * SAMPLE_RATE / MAX_BPM;
  localparam int CNT_W    = $clog2(MAX_INT + 2);
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int SUM_W    = CNT_W + PTR_W;
  localparam int FILL_W   = $clog2(DEPTH + 1);
  localparam int DIVIDEND = 60 * SAMPLE_RATE * DEPTH;
  localparam int DIV_W    = $clog2(DIVIDEND + 1);
  localparam int DCNT_W   = $clog2(DIV_W + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_TRACK   = 2'd2
  } state_t;

  state_t               state_q;
  logic                 beat_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     ring_q [DEPTH];
  logic [PTR_W-1:0]     wp_q;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic                 start_q, busy_q;
  logic [DCNT_W-1:0]    div_cnt_q;
  logic [SUM_W-1:0]     rem_q, rem_d, divisor_q;
  logic [DIV_W-1:0]     dvd_q;
  logic [BPM_WIDTH-1:0] bpm_val_q, quot_sat;
  logic                 bpm_valid_q, beat_out_q;

  logic                 edge_w, timeout_w, accept_w, handled_w, restart_w;
  logic                 div_done_w, div_ge_w;
  logic [CNT_W-1:0]     oldest_w;
  logic [SUM_W:0]       rem_sh_w;

  assign edge_w    = beat_in & ~beat_q;
  assign timeout_w = (state_q != S_IDLE) && (cnt_q == CNT_W'(MAX_INT + 1));
  assign accept_w  = edge_w && !timeout_w && (state_q != S_IDLE) && (cnt_q >= CNT_W'(MIN_INT));
  assign handled_w = (edge_w && (state_q == S_IDLE)) || accept_w;

  // Until the ring is full the slot being overwritten holds no real interval.
  assign oldest_w  = (fill_q == FILL_W'(DEPTH)) ? ring_q[wp_q] : '0;
  assign sum_d     = sum_q + SUM_W'(cnt_q) - SUM_W'(oldest_w);
  assign fill_d    = (fill_q == FILL_W'(DEPTH)) ? fill_q : fill_q + FILL_W'(1);
  assign restart_w = accept_w && (fill_d == FILL_W'(DEPTH));

  always_comb begin
    cnt_d = cnt_q;
    if (handled_w)
      cnt_d = sample_valid ? CNT_W'(1) : '0;
    else if (sample_valid && (cnt_q != CNT_W'(MAX_INT + 1)))
      cnt_d = cnt_q + CNT_W'(1);
  end

  assign rem_sh_w   = {rem_q, dvd_q[DIV_W-1]};
  assign div_ge_w   = rem_sh_w >= {1'b0, divisor_q};
  assign rem_d      = div_ge_w ? SUM_W'(rem_sh_w - {1'b0, divisor_q}) : rem_sh_w[SUM_W-1:0];
  assign div_done_w = busy_q && (div_cnt_q == '0);

  generate
    if (DIV_W > BPM_WIDTH) begin : g_sat
      assign quot_sat = (|dvd_q[DIV_W-1:BPM_WIDTH]) ? '1 : dvd_q[BPM_WIDTH-1:0];
    end else begin : g_nosat
      assign quot_sat = BPM_WIDTH'(dvd_q);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      beat_q      <= 1'b1;
      cnt_q       <= '0;
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wp_q        <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      div_cnt_q   <= '0;
      rem_q       <= '0;
      divisor_q   <= '0;
      dvd_q       <= '0;
      bpm_val_q   <= '0;
      bpm_valid_q <= 1'b0;
      beat_out_q  <= 1'b0;
    end else if (clear) begin
      state_q     <= S_IDLE;
      beat_q      <= 1'b1;
      cnt_q       <= '0;
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wp_q        <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      div_cnt_q   <= '0;
      rem_q       <= '0;
      divisor_q   <= '0;
      dvd_q       <= '0;
      bpm_val_q   <= '0;
      bpm_valid_q <= 1'b0;
      beat_out_q  <= 1'b0;
    end else begin
      beat_q      <= beat_in;
      cnt_q       <= cnt_d;
      beat_out_q  <= 1'b0;
      bpm_valid_q <= 1'b0;

      // Divider: one load cycle, DIV_W shift/subtract cycles, one publish cycle.
      if (start_q) begin
        start_q   <= 1'b0;
        busy_q    <= 1'b1;
        div_cnt_q <= DCNT_W'(DIV_W);
        rem_q     <= '0;
        divisor_q <= sum_q;
        dvd_q     <= DIV_W'(DIVIDEND);
      end else if (div_done_w) begin
        busy_q <= 1'b0;
        if (!timeout_w && !restart_w) begin
          bpm_val_q   <= quot_sat;
          bpm_valid_q <= 1'b1;
        end
      end else if (busy_q) begin
        rem_q     <= rem_d;
        dvd_q     <= {dvd_q[DIV_W-2:0], div_ge_w};
        div_cnt_q <= div_cnt_q - DCNT_W'(1);
      end

      if (timeout_w) begin
        state_q <= S_IDLE;
        fill_q  <= '0;
        sum_q   <= '0;
        wp_q    <= '0;
        start_q <= 1'b0;
        busy_q  <= 1'b0;
      end else if (edge_w && (state_q == S_IDLE)) begin
        beat_out_q <= 1'b1;
        state_q    <= S_ACQUIRE;
      end else if (accept_w) begin
        beat_out_q   <= 1'b1;
        ring_q[wp_q] <= cnt_q;
        wp_q         <= wp_q + PTR_W'(1);
        sum_q        <= sum_d;
        fill_q       <= fill_d;
        if (restart_w) begin
          start_q <= 1'b1;
          busy_q  <= 1'b0;
          if (state_q == S_ACQUIRE) state_q <= S_TRACK;
        end
      end
    end
  end

  assign bpm_val   = bpm_val_q;
  assign bpm_valid = bpm_valid_q;
  assign beat_out  = beat_out_q;
  assign locked    = (state_q == S_TRACK);
  assign state     = state_q;

endmodule
`default_nettype wire
